// File: rtl/vc_plru_update.sv
// Read-modify-write sequencer for the victim cache pseudo-LRU bit array.
// Optional VC_PLRU_STATS_EN adds saturating touch/victim counters.
module vc_plru_update #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int TREE_W   = NUM_WAYS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              touch_req,
  input  logic [WAY_W-1:0]  touch_way,
  output logic              touch_ack,
  input  logic              victim_req,
  output logic              victim_ack,
  output logic [WAY_W-1:0]  victim_way,
  output logic              busy,
  output logic              arr_read,
  output logic              arr_load,
  output logic [TREE_W-1:0] arr_datain,
  input  logic [TREE_W-1:0] arr_dataout
`ifdef VC_PLRU_STATS_EN
  ,
  output logic [15:0]       stat_touches,
  output logic [15:0]       stat_victims
`endif
);

  localparam int IDX_W = (TREE_W > 1) ? $clog2(TREE_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic               op_victim;
  logic [WAY_W-1:0]   way_q;
  logic [WAY_W-1:0]   victim_sel;
  logic               accept;

  // Walk from the root: a 0 bit sends the walk left, a 1 bit right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] t);
    logic [WAY_W-1:0] w;
    int               node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w    = w << 1;
      w[0] = t[node[IDX_W-1:0]];
      node = 2 * node + 1 + (t[node[IDX_W-1:0]] ? 1 : 0);
    end
    return w;
  endfunction

  // Every node on the way's path is pointed away from that way.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                   input logic [WAY_W-1:0]  w);
    logic [TREE_W-1:0] r;
    logic [WAY_W-1:0]  w_sh;
    logic              b;
    int                node;
    r    = t;
    w_sh = w;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b                   = w_sh[WAY_W-1];
      w_sh                = w_sh << 1;
      r[node[IDX_W-1:0]]  = ~b;
      node                = 2 * node + 1 + (b ? 1 : 0);
    end
    return r;
  endfunction

  assign victim_sel = plru_victim(arr_dataout);

  // Handshake: a request is level-held by the requester until its one-cycle
  // ack; it is sampled only in IDLE, victim taking priority over touch, and
  // must be dropped in the cycle after the ack so it is not served twice.
  assign accept = touch_req | victim_req;

  always_comb begin
    state_n    = state;
    arr_read   = 1'b0;
    arr_load   = 1'b0;
    busy       = 1'b0;
    touch_ack  = 1'b0;
    victim_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !rst) begin
          arr_read = 1'b1;
          state_n  = ST_READ;
        end
      end
      ST_READ: begin
        busy    = 1'b1;
        state_n = ST_UPDATE;
      end
      ST_UPDATE: begin
        busy       = 1'b1;
        arr_read   = 1'b1;
        arr_load   = 1'b1;
        touch_ack  = ~op_victim;
        victim_ack = op_victim;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_victim  <= 1'b0;
      way_q      <= '0;
      arr_datain <= '0;
      victim_way <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && accept) begin
        op_victim <= victim_req;
        way_q     <= touch_way;
      end
      if (state == ST_READ) begin
        if (op_victim) begin
          arr_datain <= plru_touch(arr_dataout, victim_sel);
          victim_way <= victim_sel;
        end else begin
          arr_datain <= plru_touch(arr_dataout, way_q);
        end
      end
    end
  end

`ifdef VC_PLRU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_touches <= '0;
      stat_victims <= '0;
    end else begin
      if (touch_ack && stat_touches != 16'hFFFF) stat_touches <= stat_touches + 16'd1;
      if (victim_ack && stat_victims != 16'hFFFF) stat_victims <= stat_victims + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_plru_update.sv
// Bench for vc_plru_update: array model, directed scenarios, random ops vs a
// path-search PLRU reference. Define VC_PLRU_STATS_EN to also test counters.
module tb_vc_plru_update;

  localparam int NUM_WAYS = 4;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int TREE_W   = NUM_WAYS - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              touch_req = 1'b0;
  logic [WAY_W-1:0]  touch_way = '0;
  logic              touch_ack;
  logic              victim_req = 1'b0;
  logic              victim_ack;
  logic [WAY_W-1:0]  victim_way;
  logic              busy;
  logic              arr_read;
  logic              arr_load;
  logic [TREE_W-1:0] arr_datain;
  logic [TREE_W-1:0] arr_dataout;
`ifdef VC_PLRU_STATS_EN
  logic [15:0]       stat_touches;
  logic [15:0]       stat_victims;
`endif

  int checks   = 0;
  int failures = 0;

  logic [TREE_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  vc_plru_update #(.NUM_WAYS(NUM_WAYS)) dut (
    .clk         (clk),
    .rst         (rst),
    .touch_req   (touch_req),
    .touch_way   (touch_way),
    .touch_ack   (touch_ack),
    .victim_req  (victim_req),
    .victim_ack  (victim_ack),
    .victim_way  (victim_way),
    .busy        (busy),
    .arr_read    (arr_read),
    .arr_load    (arr_load),
    .arr_datain  (arr_datain),
    .arr_dataout (arr_dataout)
`ifdef VC_PLRU_STATS_EN
    ,
    .stat_touches(stat_touches),
    .stat_victims(stat_victims)
`endif
  );

  // ---------------- downstream array model ----------------
  logic [TREE_W-1:0] arr_mem = '0;
  logic [TREE_W-1:0] arr_q   = '0;
  logic              preset_en = 1'b0;
  logic [TREE_W-1:0] preset_val = '0;
  int                load_cnt = 0;

  assign arr_dataout = arr_q;

  always @(posedge clk) begin
    if (preset_en) arr_mem <= preset_val;
    else if (arr_load) arr_mem <= arr_datain;
    if (arr_read) arr_q <= arr_load ? arr_datain : arr_mem;
    if (arr_load) load_cnt <= load_cnt + 1;
  end

  // ---------------- reference model ----------------
  int model_tree = 0;

  // Victim = the one way whose whole root-to-leaf path points toward it.
  function automatic int model_victim(input int tree);
    int node, dir;
    bit ok;
    for (int w = 0; w < NUM_WAYS; w++) begin
      ok = 1'b1;
      for (int l = 0; l < WAY_W; l++) begin
        node = (1 << l) - 1 + (w >> (WAY_W - l));
        dir  = (w >> (WAY_W - 1 - l)) & 1;
        if (((tree >> node) & 1) != dir) ok = 1'b0;
      end
      if (ok) return w;
    end
    return -1;
  endfunction

  function automatic int model_touch(input int tree, input int w);
    int t, node, dir;
    t = tree;
    for (int l = 0; l < WAY_W; l++) begin
      node = (1 << l) - 1 + (w >> (WAY_W - l));
      dir  = (w >> (WAY_W - 1 - l)) & 1;
      if (dir == 1) t = t & ~(1 << node);
      else          t = t | (1 << node);
    end
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input int v);
    preset_val = TREE_W'(v);
    preset_en  = 1'b1;
    @(posedge clk); #1;
    preset_en  = 1'b0;
    model_tree = v;
  endtask

  // Starts and ends at posedge+1 with the DUT idle; cycle 0 is the issue cycle.
  task automatic drive_op(input bit is_victim, input int way,
                          output int ack_cyc, output bit got_victim_ack,
                          output int vway, output int din,
                          output int loads, output bit rd0);
    int cyc;
    cyc = 0; loads = 0; ack_cyc = -1; got_victim_ack = 1'b0; vway = -1; din = -1;
    if (is_victim) victim_req = 1'b1;
    else begin
      touch_way = WAY_W'(way);
      touch_req = 1'b1;
    end
    #1;
    rd0 = arr_read;
    if (arr_load) loads++;
    while (cyc < 8 && ack_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (arr_load) loads++;
      if (victim_ack || touch_ack) begin
        ack_cyc        = cyc;
        got_victim_ack = victim_ack;
        vway           = int'(victim_way);
        din            = int'(arr_datain);
        victim_req     = 1'b0;
        touch_req      = 1'b0;
      end
    end
    victim_req = 1'b0;
    touch_req  = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({arr_read, arr_load, busy, touch_ack, victim_ack} !== 5'b0 ||
        victim_way !== '0 || arr_datain !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%b ld=%b busy=%b tack=%b vack=%b vway=%0d din=%b, required all 0",
               arr_read, arr_load, busy, touch_ack, victim_ack, victim_way, arr_datain);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || arr_read !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b rd=%b, required 0 0", busy, arr_read);
    end
  endtask

  task automatic test_victim_seq;
    int exp_way[3] = '{0, 2, 1};
    int exp_din[3] = '{3'b011, 3'b110, 3'b101};
    int ac, vw, dn, ld;
    bit gv, rd0;
    preload(0);
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b1, 0, ac, gv, vw, dn, ld, rd0);
      model_tree = model_touch(model_tree, model_victim(model_tree));
      checks++;
      if (ac != 2 || !gv || !rd0 || ld != 1) begin
        failures++;
        $display("FAIL victim_timing[%0d]: ack_cycle=%0d vack=%b rd0=%b loads=%0d, required 2 1 1 1",
                 i, ac, gv, rd0, ld);
      end
      checks++;
      if (vw != exp_way[i] || dn != exp_din[i]) begin
        failures++;
        $display("FAIL victim_seq[%0d]: way=%0d din=%0d, required way=%0d din=%0d",
                 i, vw, dn, exp_way[i], exp_din[i]);
      end
    end
  endtask

  task automatic test_touch;
    int ways[2]    = '{3, 1};
    int exp_din[2] = '{3'b000, 3'b001};
    int ac, vw, dn, ld;
    bit gv, rd0;
    preload(0);
    for (int i = 0; i < 2; i++) begin
      drive_op(1'b0, ways[i], ac, gv, vw, dn, ld, rd0);
      checks++;
      if (ac != 2 || gv || dn != exp_din[i] || ld != 1) begin
        failures++;
        $display("FAIL touch[%0d]: ack_cycle=%0d vack=%b din=%0d loads=%0d, required 2 0 %0d 1",
                 i, ac, gv, dn, ld, exp_din[i]);
      end
    end
    checks++;
    if (arr_mem !== 3'b001) begin
      failures++;
      $display("FAIL touch_array: array=%b, required 001", arr_mem);
    end
  endtask

  task automatic test_both_requests;
    int vack_cyc, tack_cyc, loads, cyc;
    preload(0);
    vack_cyc = -1; tack_cyc = -1; loads = 0; cyc = 0;
    touch_way  = 2'd3;
    touch_req  = 1'b1;
    victim_req = 1'b1;
    while (cyc < 12 && tack_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (arr_load) loads++;
      if (victim_ack) begin
        if (vack_cyc < 0) vack_cyc = cyc;
        victim_req = 1'b0;
      end
      if (touch_ack) begin
        tack_cyc  = cyc;
        touch_req = 1'b0;
      end
    end
    victim_req = 1'b0;
    touch_req  = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (vack_cyc != 2 || tack_cyc != 5 || loads != 2) begin
      failures++;
      $display("FAIL both_req: vack_cycle=%0d tack_cycle=%0d loads=%0d, required 2 5 2",
               vack_cyc, tack_cyc, loads);
    end
    // victim of 000 is way 0 -> 011; then touch way 3 -> 010
    checks++;
    if (arr_mem !== 3'b010) begin
      failures++;
      $display("FAIL both_req_array: array=%b, required 010", arr_mem);
    end
    model_tree = 3'b010;
  endtask

  task automatic test_reset_mid_op;
    int loads_before, ac, vw, dn, ld, ev;
    bit gv, rd0;
    preload(3'b011);
    loads_before = load_cnt;
    victim_req = 1'b1;
    @(posedge clk); #1;
    victim_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_op_in_read: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({arr_read, arr_load, busy, touch_ack, victim_ack} !== 5'b0 ||
        victim_way !== '0 || arr_datain !== '0) begin
      failures++;
      $display("FAIL mid_op_reset_outputs: rd=%b ld=%b busy=%b tack=%b vack=%b vway=%0d din=%b, required all 0",
               arr_read, arr_load, busy, touch_ack, victim_ack, victim_way, arr_datain);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (load_cnt != loads_before || arr_mem !== 3'b011) begin
      failures++;
      $display("FAIL mid_op_no_load: loads=%0d array=%b, required %0d 011",
               load_cnt - loads_before, arr_mem, 0);
    end
    drive_op(1'b1, 0, ac, gv, vw, dn, ld, rd0);
    ev = model_victim(model_tree);
    model_tree = model_touch(model_tree, ev);
    checks++;
    if (ac != 2 || !gv || vw != ev || dn != model_tree) begin
      failures++;
      $display("FAIL mid_op_recover: ack_cycle=%0d way=%0d din=%0d, required 2 %0d %0d",
               ac, vw, dn, ev, model_tree);
    end
  endtask

  task automatic test_random_ops;
    int ac, vw, dn, ld, ev, w;
    bit gv, rd0, is_v;
    logic [TREE_W-1:0] exp_din;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) preload($urandom_range(0, (1 << TREE_W) - 1));
      is_v = 1'($urandom_range(0, 1));
      w    = $urandom_range(0, NUM_WAYS - 1);
      ev   = model_victim(model_tree);
      model_tree = model_touch(model_tree, is_v ? ev : w);
      exp_q.push_back(TREE_W'(model_tree));
      drive_op(is_v, w, ac, gv, vw, dn, ld, rd0);
      exp_din = exp_q.pop_front();
      checks++;
      if (ac != 2 || gv != is_v || ld != 1 || dn != int'(exp_din) ||
          (is_v && vw != ev) || arr_mem !== exp_din) begin
        failures++;
        $display("FAIL random[%0d]: victim_op=%b ack_cycle=%0d vack=%b loads=%0d way=%0d din=%0d array=%0d, required ack_cycle=2 way=%0d din=%0d",
                 i, is_v, ac, gv, ld, vw, dn, arr_mem, ev, exp_din);
      end
    end
  endtask

`ifdef VC_PLRU_STATS_EN
  task automatic test_stats;
    int ac, vw, dn, ld;
    bit gv, rd0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) drive_op(1'b1, 0, ac, gv, vw, dn, ld, rd0);
    for (int i = 0; i < 2; i++) drive_op(1'b0, i, ac, gv, vw, dn, ld, rd0);
    checks++;
    if (stat_victims !== 16'd3 || stat_touches !== 16'd2) begin
      failures++;
      $display("FAIL stats_count: victims=%0d touches=%0d, required 3 2", stat_victims, stat_touches);
    end
    force dut.stat_victims = 16'hFFFF;
    force dut.stat_touches = 16'hFFFF;
    @(posedge clk); #1;
    release dut.stat_victims;
    release dut.stat_touches;
    drive_op(1'b1, 0, ac, gv, vw, dn, ld, rd0);
    drive_op(1'b0, 2, ac, gv, vw, dn, ld, rd0);
    checks++;
    if (stat_victims !== 16'hFFFF || stat_touches !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_saturate: victims=%h touches=%h, required ffff ffff", stat_victims, stat_touches);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_victim_seq();
    test_touch();
    test_both_requests();
    test_reset_mid_op();
    test_random_ops();
`ifdef VC_PLRU_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
